// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: decoded-instruction struct,
// memory-stage FSM states and opcode classification helpers.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDI = 4'd1,
    OP_LUI  = 4'd2,
    OP_JAL  = 4'd3,
    OP_LW   = 4'd4,
    OP_SW   = 4'd5,
    OP_BEQ  = 4'd6,
    OP_BNE  = 4'd7,
    OP_BLT  = 4'd8,
    OP_BGE  = 4'd9,
    OP_BLTU = 4'd10,
    OP_BGEU = 4'd11
  } opcode_t;

  // Decoded instruction as seen by the back end of the pipeline.
  typedef struct packed {
    opcode_t op;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_t;

  function automatic logic is_mem_op(input opcode_t op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Stores and branches retire without touching the register file.
  function automatic logic writes_rd(input opcode_t op);
    case (op)
      OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through, or performs one lw/sw access
// with address-range checking and an ack timeout, then pulses completed.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enabled,
  input  instr_t            instr,
  input  logic [31:0]       alu_rd,
  input  logic [31:0]       rs2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              completed,
  output logic              wb_en,
  output logic [31:0]       wb_data,
  output logic              err,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  // Handshake: mem_req is high for every ACCESS cycle; the request (we,
  // addr, wdata) is stable while mem_req is high and completes in the
  // cycle mem_ack is sampled high. completed is a one-cycle strobe.

  mem_state_t        state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       wdata_nxt;
  logic              wb_en_nxt;
  logic [31:0]       wb_data_nxt;
  logic              err_nxt;
  logic              addr_bad;

  // Any address bit above the data-memory window makes the access illegal.
  assign addr_bad = (alu_rd >> ADDR_W) != 32'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_en     <= 1'b0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      wb_en     <= wb_en_nxt;
      wb_data   <= wb_data_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    we_nxt      = mem_we;
    addr_nxt    = mem_addr;
    wdata_nxt   = mem_wdata;
    wb_en_nxt   = wb_en;
    wb_data_nxt = wb_data;
    err_nxt     = err;
    case (state)
      ST_IDLE: begin
        if (enabled) begin
          if (!is_mem_op(instr.op)) begin
            state_nxt   = ST_DONE;
            wb_data_nxt = alu_rd;
            wb_en_nxt   = writes_rd(instr.op);
            err_nxt     = 1'b0;
          end else if (addr_bad) begin
            state_nxt   = ST_DONE;
            wb_data_nxt = '0;
            wb_en_nxt   = 1'b0;
            err_nxt     = 1'b1;
          end else begin
            state_nxt = ST_ACCESS;
            wait_nxt  = '0;
            we_nxt    = (instr.op == OP_SW);
            addr_nxt  = alu_rd[ADDR_W-1:0];
            wdata_nxt = rs2;
          end
        end
      end
      ST_ACCESS: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          state_nxt   = ST_DONE;
          wb_data_nxt = mem_we ? 32'd0 : mem_rdata;
          wb_en_nxt   = !mem_we;
          err_nxt     = 1'b0;
          we_nxt      = 1'b0;
        end else if (wait_cnt == LAST_WAIT) begin
          state_nxt   = ST_DONE;
          wb_data_nxt = '0;
          wb_en_nxt   = 1'b0;
          err_nxt     = 1'b1;
          we_nxt      = 1'b0;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        wait_nxt  = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign mem_req   = (state == ST_ACCESS);
  assign completed = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, lw/sw accesses, address
// fault, ack timeout and reset during an outstanding access.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int ADDR_W   = 16;
  localparam int MAX_WAIT = 4;

  logic              clk;
  logic              rstn;
  logic              enabled;
  instr_t            instr;
  logic [31:0]       alu_rd;
  logic [31:0]       rs2;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              completed;
  logic              wb_en;
  logic [31:0]       wb_data;
  logic              err;
  logic              busy;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enabled   (enabled),
    .instr     (instr),
    .alu_rd    (alu_rd),
    .rs2       (rs2),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .completed (completed),
    .wb_en     (wb_en),
    .wb_data   (wb_data),
    .err       (err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input opcode_t op, input logic [31:0] a, input logic [31:0] d);
    enabled  = 1'b1;
    instr.op = op;
    alu_rd   = a;
    rs2      = d;
    step();
    enabled  = 1'b0;
  endtask

  initial begin
    rstn      = 1'b0;
    enabled   = 1'b0;
    instr.op  = OP_ADD;
    alu_rd    = '0;
    rs2       = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (3) step();
    check("rst_req",   mem_req,   0);
    check("rst_busy",  busy,      0);
    check("rst_comp",  completed, 0);
    check("rst_wbdat", wb_data,   0);
    check("rst_err",   err,       0);
    rstn = 1'b1;
    step();

    // addi pass-through
    issue(OP_ADDI, 32'h0000_0005, 32'h0);
    check("addi_comp",  completed, 1);
    check("addi_wben",  wb_en,     1);
    check("addi_wbdat", wb_data,   32'h5);
    check("addi_err",   err,       0);
    check("addi_req",   mem_req,   0);
    step();
    check("addi_idle",  busy,      0);
    check("addi_hold",  wb_data,   32'h5);

    // lw, ack arrives 3 cycles after mem_req rises
    issue(OP_LW, 32'h0000_0010, 32'h0);
    check("lw_req0",  mem_req,  1);
    check("lw_addr0", mem_addr, 32'h10);
    check("lw_we0",   mem_we,   0);
    issue(OP_ADDI, 32'h0000_0099, 32'h0);
    check("lw_ignen_st", state_dbg, 32'(ST_ACCESS));
    check("lw_addr1",    mem_addr,  32'h10);
    step();
    check("lw_req2",  mem_req,  1);
    step();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    check("lw_req3",  mem_req,  1);
    check("lw_addr3", mem_addr, 32'h10);
    check("lw_we3",   mem_we,   0);
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("lw_comp",  completed, 1);
    check("lw_wbdat", wb_data,   32'hDEAD_BEEF);
    check("lw_wben",  wb_en,     1);
    check("lw_err",   err,       0);
    check("lw_reqlo", mem_req,   0);
    step();

    // sw, acked in the first access cycle
    issue(OP_SW, 32'h0000_0020, 32'h0000_1234);
    check("sw_req",   mem_req,   1);
    check("sw_we",    mem_we,    1);
    check("sw_wdata", mem_wdata, 32'h1234);
    check("sw_addr",  mem_addr,  32'h20);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("sw_comp",  completed, 1);
    check("sw_wben",  wb_en,     0);
    check("sw_err",   err,       0);
    step();

    // lw out of the data-memory window
    issue(OP_LW, 32'hFFFF_FFFF, 32'h0);
    check("bad_req",   mem_req,   0);
    check("bad_comp",  completed, 1);
    check("bad_err",   err,       1);
    check("bad_wben",  wb_en,     0);
    check("bad_wbdat", wb_data,   0);
    step();

    // sw that is never acked: times out after MAX_WAIT cycles
    issue(OP_SW, 32'h0000_0030, 32'h0000_5555);
    for (int i = 0; i < MAX_WAIT; i++) begin
      check($sformatf("to_req%0d", i), mem_req, 1);
      check($sformatf("to_cmp%0d", i), completed, 0);
      step();
    end
    check("to_reqlo", mem_req,   0);
    check("to_comp",  completed, 1);
    check("to_err",   err,       1);
    check("to_wben",  wb_en,     0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("late_comp", completed, 0);
    check("late_busy", busy,      0);
    check("late_err",  err,       1);
    step();
    check("late_comp2", completed, 0);

    // reset in the middle of an access
    issue(OP_LW, 32'h0000_0040, 32'h0);
    check("rma_req", mem_req, 1);
    step();
    #2;
    rstn = 1'b0;
    #1;
    check("rma_req0",  mem_req,  0);
    check("rma_busy",  busy,     0);
    check("rma_addr",  mem_addr, 0);
    check("rma_err",   err,      0);
    check("rma_wbdat", wb_data,  0);
    #2;
    rstn = 1'b1;
    step();
    check("rma_comp", completed, 0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    step();
    mem_ack   = 1'b0;
    check("rma_ack_comp", completed, 0);
    check("rma_ack_wb",   wb_data,   0);
    issue(OP_ADDI, 32'h0000_0007, 32'h0);
    check("post_comp",  completed, 1);
    check("post_wbdat", wb_data,   32'h7);
    check("post_wben",  wb_en,     1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
